// File: rtl/viterbi_acs_spm.sv
// Hamming-metric add-compare-select for the K=3 (7,5) 4-state Viterbi decoder, with survivor memory
// that is replayed newest-first into the traceback stage once a frame has been accepted.
module viterbi_acs_spm #(
  parameter int FRAME_LEN = 8,
  parameter int PM_W      = 6,
  parameter int INIT_PM   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       sym_valid,
  input  logic [1:0] sym_in,
  output logic       sym_ready,
  output logic       en_tbck,
  output logic [1:0] bck_prv_st_00,
  output logic [1:0] bck_prv_st_01,
  output logic [1:0] bck_prv_st_10,
  output logic [1:0] bck_prv_st_11,
  output logic [1:0] sel_node,
  output logic       frame_done
);

  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CW = $clog2(FRAME_LEN + 2);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] TB_CYCLES = CW'(FRAME_LEN + 1);
  localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_ACS, S_TB, S_DONE} state_t;

  state_t          state;
  logic [PM_W-1:0] pm [4];
  logic [7:0]      mem [FRAME_LEN];
  logic [AW-1:0]   addr;
  logic [AW-1:0]   rd_addr;
  logic [CW-1:0]   tb_cnt;

  logic [1:0]      pa [4];
  logic [1:0]      pb [4];
  logic [PM_W:0]   ca [4];
  logic [PM_W:0]   cb [4];
  logic [PM_W:0]   cand [4];
  logic [PM_W:0]   diff [4];
  logic [1:0]      dec [4];
  logic [PM_W-1:0] pm_nxt [4];
  logic [PM_W:0]   mn;
  logic [1:0]      best;
  logic [7:0]      dec_word;

  // Hamming distance between the received symbol and the branch label of p->n.
  function automatic logic [1:0] bm(input logic [1:0] p, input logic [1:0] n, input logic [1:0] sym);
    logic       u;
    logic [1:0] d;
    u = n[1];
    d = sym ^ {u ^ p[1] ^ p[0], u ^ p[0]};
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      pa[n] = (n % 2 == 1) ? 2'd2 : 2'd0;
      pb[n] = pa[n] | 2'd1;
      ca[n] = {1'b0, pm[pa[n]]} + {{(PM_W-1){1'b0}}, bm(pa[n], 2'(n), sym_in)};
      cb[n] = {1'b0, pm[pb[n]]} + {{(PM_W-1){1'b0}}, bm(pb[n], 2'(n), sym_in)};
      if (ca[n] <= cb[n]) begin
        cand[n] = ca[n];
        dec[n]  = pa[n];
      end else begin
        cand[n] = cb[n];
        dec[n]  = pb[n];
      end
    end
    mn = cand[0];
    for (int n = 1; n < 4; n++)
      if (cand[n] < mn) mn = cand[n];
    for (int n = 0; n < 4; n++) begin
      diff[n]   = cand[n] - mn;
      pm_nxt[n] = (diff[n] > PM_MAX) ? PM_MAX[PM_W-1:0] : diff[n][PM_W-1:0];
    end
    // Strict compare keeps the lowest index on ties.
    best = 2'd0;
    for (int n = 1; n < 4; n++)
      if (pm_nxt[n] < pm_nxt[best]) best = 2'(n);
    dec_word = {dec[3], dec[2], dec[1], dec[0]};
  end

  always_ff @(posedge clk)
    if (state == S_ACS && sym_valid) mem[addr] <= dec_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      pm[0]         <= '0;
      pm[1]         <= PM_W'(INIT_PM);
      pm[2]         <= PM_W'(INIT_PM);
      pm[3]         <= PM_W'(INIT_PM);
      addr          <= '0;
      rd_addr       <= '0;
      tb_cnt        <= '0;
      sym_ready     <= 1'b0;
      en_tbck       <= 1'b0;
      bck_prv_st_00 <= '0;
      bck_prv_st_01 <= '0;
      bck_prv_st_10 <= '0;
      bck_prv_st_11 <= '0;
      sel_node      <= '0;
      frame_done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            pm[0]     <= '0;
            pm[1]     <= PM_W'(INIT_PM);
            pm[2]     <= PM_W'(INIT_PM);
            pm[3]     <= PM_W'(INIT_PM);
            addr      <= '0;
            sym_ready <= 1'b1;
            state     <= S_ACS;
          end
        end
        S_ACS: begin
          if (sym_valid) begin
            for (int n = 0; n < 4; n++) pm[n] <= pm_nxt[n];
            addr <= addr + 1'b1;
            if (addr == LAST_ADDR) begin
              addr      <= '0;
              sel_node  <= best;
              rd_addr   <= LAST_ADDR;
              tb_cnt    <= '0;
              sym_ready <= 1'b0;
              state     <= S_TB;
            end
          end
        end
        S_TB: begin
          // Address 0 is presented twice so the traceback sees FRAME_LEN+1 enables.
          if (tb_cnt != TB_CYCLES) begin
            {bck_prv_st_11, bck_prv_st_10, bck_prv_st_01, bck_prv_st_00} <= mem[rd_addr];
            en_tbck <= 1'b1;
            tb_cnt  <= tb_cnt + 1'b1;
            if (rd_addr != '0) rd_addr <= rd_addr - 1'b1;
          end else begin
            en_tbck    <= 1'b0;
            frame_done <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          frame_done <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_acs_spm.sv
// Randomised and directed frames against a trellis-level reference model; checks replay order and timing.
module tb_viterbi_acs_spm;

  localparam int FL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       sym_valid;
  logic [1:0] sym_in;
  logic       sym_ready;
  logic       en_tbck;
  logic [1:0] bck_prv_st_00, bck_prv_st_01, bck_prv_st_10, bck_prv_st_11;
  logic [1:0] sel_node;
  logic       frame_done;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] sym_q [FL];
  int         gap [FL];
  logic [7:0] exp_dec [FL];
  logic [1:0] exp_sel;

  viterbi_acs_spm dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .sym_valid     (sym_valid),
    .sym_in        (sym_in),
    .sym_ready     (sym_ready),
    .en_tbck       (en_tbck),
    .bck_prv_st_00 (bck_prv_st_00),
    .bck_prv_st_01 (bck_prv_st_01),
    .bck_prv_st_10 (bck_prv_st_10),
    .bck_prv_st_11 (bck_prv_st_11),
    .sel_node      (sel_node),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Encoder output for leaving state p with input bit u, state = {newest bit, older bit}.
  function automatic int branch_dist(int p, int n, logic [1:0] s);
    int u, b1, b0, c0, c1;
    u  = n / 2;
    b1 = p / 2;
    b0 = p % 2;
    c0 = u ^ b1 ^ b0;
    c1 = u ^ b0;
    return ((s[1] != c0[0]) ? 1 : 0) + ((s[0] != c1[0]) ? 1 : 0);
  endfunction

  task automatic model_frame();
    int pmv [4];
    int newv [4];
    int prv [4];
    int mn, bi;
    pmv = '{0, 16, 16, 16};
    for (int t = 0; t < FL; t++) begin
      for (int n = 0; n < 4; n++) begin
        int lo, a, b;
        lo = (n % 2) * 2;
        a  = pmv[lo]     + branch_dist(lo,     n, sym_q[t]);
        b  = pmv[lo + 1] + branch_dist(lo + 1, n, sym_q[t]);
        newv[n] = (a <= b) ? a : b;
        prv[n]  = (a <= b) ? lo : lo + 1;
      end
      mn = newv[0];
      for (int n = 1; n < 4; n++) if (newv[n] < mn) mn = newv[n];
      for (int n = 0; n < 4; n++) begin
        pmv[n] = newv[n] - mn;
        if (pmv[n] > 63) pmv[n] = 63;
        exp_dec[t][2*n +: 2] = 2'(prv[n]);
      end
    end
    bi = 0;
    for (int n = 1; n < 4; n++) if (pmv[n] < pmv[bi]) bi = n;
    exp_sel = 2'(bi);
  endtask

  // Entered and left at a negedge; the next frame may start right away (cycle after frame_done).
  task automatic run_frame();
    logic [10:0] en_seq, fd_seq;
    int rd;
    model_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int t = 0; t < FL; t++) begin
      for (int g = 0; g < gap[t]; g++) begin
        sym_valid = 1'b0;
        sym_in    = 2'($urandom);
        @(negedge clk);
      end
      check("sym_ready_acs", 32'(sym_ready), 32'd1);
      sym_valid = 1'b1;
      sym_in    = sym_q[t];
      @(negedge clk);
    end
    en_seq = '0;
    fd_seq = '0;
    rd     = FL - 1;
    for (int k = 0; k < 11; k++) begin
      en_seq[k] = en_tbck;
      fd_seq[k] = frame_done;
      if (en_tbck) begin
        check("replay_dec", 32'({bck_prv_st_11, bck_prv_st_10, bck_prv_st_01, bck_prv_st_00}),
              32'(exp_dec[rd]));
        check("sel_node", 32'(sel_node), 32'(exp_sel));
        if (rd > 0) rd--;
      end
      // Symbols offered during replay must be dropped; frame_start during frame_done ignored.
      sym_valid   = (k < 10);
      sym_in      = 2'($urandom);
      frame_start = (k == 10);
      @(negedge clk);
    end
    frame_start = 1'b0;
    sym_valid   = 1'b0;
    check("en_tbck_window", 32'(en_seq), 32'h3FE);
    check("frame_done_pulse", 32'(fd_seq), 32'h400);
    check("idle_after_done", 32'({sym_ready, en_tbck, frame_done}), 32'd0);
  endtask

  task automatic set_frame(input logic [15:0] syms, input int gap_mode);
    for (int t = 0; t < FL; t++) begin
      sym_q[t] = syms[15 - 2*t -: 2];
      case (gap_mode)
        0:       gap[t] = 0;
        1:       gap[t] = (t > 0) ? 1 : 0;
        default: gap[t] = $urandom_range(0, 2);
      endcase
    end
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    sym_valid   = 1'b0;
    sym_in      = 2'b00;
    #1;
    check("reset_outputs", 32'({sym_ready, en_tbck, bck_prv_st_00, bck_prv_st_01, bck_prv_st_10,
                                bck_prv_st_11, sel_node, frame_done}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(sym_ready), 32'd0);

    set_frame(16'b00_00_00_00_00_00_00_00, 0); run_frame();   // all-zero
    set_frame(16'b11_10_11_00_00_00_00_00, 0); run_frame();   // impulse
    set_frame(16'b01_10_11_00_00_00_00_00, 0); run_frame();   // impulse with one bit error
    set_frame(16'b11_10_11_00_00_00_00_00, 1); run_frame();   // impulse, gapped valid
    set_frame(16'b01_01_01_01_01_01_01_01, 0); run_frame();   // tie-break pattern

    // Reset in the middle of a frame.
    set_frame(16'($urandom), 0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      sym_valid = 1'b1;
      sym_in    = sym_q[t];
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("midframe_reset", 32'({sym_ready, en_tbck, bck_prv_st_00, bck_prv_st_01, bck_prv_st_10,
                                 bck_prv_st_11, sel_node, frame_done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      sym_in = 2'($urandom);
      @(negedge clk);
      check("no_burst_after_reset", 32'({sym_ready, en_tbck, frame_done}), 32'd0);
    end
    sym_valid = 1'b0;
    set_frame(16'($urandom), 0); run_frame();

    for (int f = 0; f < 8; f++) begin
      set_frame(16'($urandom), 2);
      run_frame();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
